// File: rtl/load_store_unit.sv
// load_store_unit
//
// Core-side initiator for a word-addressed data memory. It accepts one
// load/store request at a time and converts the byte address into a word index.
// Sub-word stores are done as read-modify-write. Load data is returned
// sign/zero-extended together with a one-cycle resp_valid pulse.
//
// Optional feature macro: LSU_ALIGN_CHECK_EN
//   defined   : misaligned halfword/word accesses are rejected with resp_err.
//   undefined : no alignment check; halfword lane is addr[1] and word
//               accesses ignore addr[1:0].
//
// Ports
//   clk, rst_n                 clock, synchronous active-low reset
//   req_valid / req_ready      request handshake (ready only in IDLE)
//   req_we, req_funct3         direction (1 = store) and RV32I width code
//   req_addr, req_wdata        byte address, store data
//   resp_valid                 one-cycle completion pulse
//   resp_rdata, resp_err       load result / rejection flag (qualified by resp_valid)
//   mem_addr, mem_wd           word index and write data to memory
//   mem_we, mem_read           memory write / read enables (never both high)
//   mem_rd                     combinational memory read data

module load_store_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 65
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [DATA_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wd,
    output logic                  mem_we,
    output logic                  mem_read,
    input  logic [DATA_WIDTH-1:0] mem_rd
);

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        WRITE,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic                  op_we;
    logic [2:0]            op_funct3;
    logic [1:0]            op_lane;
    logic [DATA_WIDTH-1:0] op_wdata;
    logic [DATA_WIDTH-1:0] index_q;
    logic [DATA_WIDTH-1:0] merged_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  err_q;

    logic [DATA_WIDTH-1:0] req_index;
    logic                  funct3_ok;
    logic                  range_ok;
    logic                  align_ok;
    logic                  req_bad;
    logic                  accept;
    logic                  word_store;
    logic [7:0]            byte_sel;
    logic [15:0]           half_sel;
    logic [DATA_WIDTH-1:0] load_data;
    logic [DATA_WIDTH-1:0] merged_next;
    logic                  mem_read_c;
    logic                  mem_we_c;

    assign accept     = req_valid && (state == IDLE);
    assign req_index  = req_addr >> 2;
    assign range_ok   = req_index < DATA_WIDTH'(DEPTH);
    assign req_bad    = !(funct3_ok && range_ok && align_ok);
    assign word_store = op_we && (op_funct3 == F3_W);

    // Width codes legal for the request direction; stores have no unsigned forms.
    always_comb begin
        funct3_ok = 1'b0;
        if (req_we) begin
            funct3_ok = (req_funct3 == F3_B) || (req_funct3 == F3_H) || (req_funct3 == F3_W);
        end else begin
            funct3_ok = (req_funct3 == F3_B) || (req_funct3 == F3_H) || (req_funct3 == F3_W) ||
                        (req_funct3 == F3_BU) || (req_funct3 == F3_HU);
        end
    end

    // Alignment rule; funct3[1:0]==01 covers LH, LHU and SH.
`ifdef LSU_ALIGN_CHECK_EN
    always_comb begin
        align_ok = 1'b1;
        if ((req_funct3[1:0] == 2'b01) && req_addr[0]) begin
            align_ok = 1'b0;
        end
        if ((req_funct3 == F3_W) && (req_addr[1:0] != 2'b00)) begin
            align_ok = 1'b0;
        end
    end
`else
    assign align_ok = 1'b1;
`endif

    // Halfwords always use lane bit 1, which is the forced lane when the
    // alignment check is off and equals the true lane when it is on.
    assign byte_sel = mem_rd[{op_lane, 3'b000} +: 8];
    assign half_sel = mem_rd[{op_lane[1], 4'b0000} +: 16];

    // Load result extension.
    always_comb begin
        load_data = mem_rd;
        case (op_funct3)
            F3_B:    load_data = {{(DATA_WIDTH-8){byte_sel[7]}}, byte_sel};
            F3_H:    load_data = {{(DATA_WIDTH-16){half_sel[15]}}, half_sel};
            F3_BU:   load_data = {{(DATA_WIDTH-8){1'b0}}, byte_sel};
            F3_HU:   load_data = {{(DATA_WIDTH-16){1'b0}}, half_sel};
            default: load_data = mem_rd;
        endcase
    end

    // Read-modify-write merge: replace the addressed byte or halfword.
    always_comb begin
        merged_next = mem_rd;
        if (op_funct3 == F3_H) begin
            merged_next[{op_lane[1], 4'b0000} +: 16] = op_wdata[15:0];
        end else begin
            merged_next[{op_lane, 3'b000} +: 8] = op_wdata[7:0];
        end
    end

    // Next state and memory strobes.
    always_comb begin
        state_next = state;
        mem_read_c = 1'b0;
        mem_we_c   = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = req_bad ? DONE : ACCESS;
                end
            end
            ACCESS: begin
                if (!op_we) begin
                    mem_read_c = 1'b1;
                    state_next = DONE;
                end else if (word_store) begin
                    mem_we_c   = 1'b1;
                    state_next = DONE;
                end else begin
                    mem_read_c = 1'b1;
                    state_next = WRITE;
                end
            end
            WRITE: begin
                mem_we_c   = 1'b1;
                state_next = DONE;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // State register and latched request/response data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            op_we     <= 1'b0;
            op_funct3 <= 3'b000;
            op_lane   <= 2'b00;
            op_wdata  <= '0;
            index_q   <= '0;
            merged_q  <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_we     <= req_we;
                        op_funct3 <= req_funct3;
                        op_lane   <= req_addr[1:0];
                        op_wdata  <= req_wdata;
                        index_q   <= req_index;
                        rdata_q   <= '0;
                        err_q     <= req_bad;
                    end
                end
                ACCESS: begin
                    if (!op_we) begin
                        rdata_q <= load_data;
                    end else if (!word_store) begin
                        merged_q <= merged_next;
                    end
                end
                DONE: begin
                    rdata_q <= '0;
                    err_q   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Strobes are gated by rst_n so a reset edge can never commit a write.
    assign mem_read   = rst_n && mem_read_c;
    assign mem_we     = rst_n && mem_we_c;
    assign mem_addr   = index_q;
    assign mem_wd     = (state == WRITE) ? merged_q : op_wdata;
    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == DONE);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit
//
// Directed bench for load_store_unit. A word-array memory sits on the memory
// port. A reference memory plus request-level model predicts each response
// (data, error, latency, number of memory-access cycles). One monitor compares
// every response and memory access against those predictions. Literal checks
// from the hand-worked examples pin the model.

module tb_load_store_unit;

    localparam int DEPTH = 65;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wd;
    logic        mem_we;
    logic        mem_read;
    logic [31:0] mem_rd;

    load_store_unit #(.DATA_WIDTH(32), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_addr   (mem_addr),
        .mem_wd     (mem_wd),
        .mem_we     (mem_we),
        .mem_read   (mem_read),
        .mem_rd     (mem_rd)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          acc;
        logic [31:0] idx;
        int          acceptCyc;
        int          seenAcc;
    } expect_t;

    logic [31:0] mem     [0:DEPTH-1];
    logic [31:0] ref_mem [0:DEPTH-1];

    expect_t     pending[$];
    expect_t     cur;
    bit          curValid = 1'b0;
    bit          monitorQuiet = 1'b0;
    bit          prevResp = 1'b0;
    int          acceptLog[$];
    int          cyc = 0;
    int          respCount = 0;
    int          total = 0;
    int          bad = 0;
    logic [31:0] lastRdata = '0;
    logic        lastErr = 1'b0;

    // Data memory: combinational read while mem_read, write on the rising edge.
    assign mem_rd = (mem_read && (mem_addr < DEPTH)) ? mem[mem_addr[6:0]] : 32'h0;

    always @(posedge clk) begin
        if (mem_we && (mem_addr < DEPTH)) begin
            mem[mem_addr[6:0]] = mem_wd;
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    task automatic preloadWord(input int idx, input logic [31:0] val);
        mem[idx]     = val;
        ref_mem[idx] = val;
    endtask

    // Request-level model: decides legality and predicts the result, then
    // applies stores to the reference memory.
    function automatic expect_t modelReq(input logic we, input logic [2:0] f3,
                                         input logic [31:0] addr, input logic [31:0] wdata);
        expect_t     e;
        logic [31:0] idxv;
        logic [31:0] word;
        logic [31:0] b;
        logic [31:0] h;
        logic [31:0] m8;
        logic [31:0] m16;
        bit          legal;
        bit          aligned;
        int          bsh;
        int          hsh;
        idxv = addr >> 2;
        e.idx = idxv;
        e.acceptCyc = 0;
        e.seenAcc = 0;
        e.rdata = 32'h0;
        e.err = 1'b0;
        legal = we ? (f3 <= 3'd2) : ((f3 <= 3'd2) || (f3 == 3'd4) || (f3 == 3'd5));
        aligned = 1'b1;
`ifdef LSU_ALIGN_CHECK_EN
        if ((f3 == 3'd1 || f3 == 3'd5) && addr[0]) aligned = 1'b0;
        if (f3 == 3'd2 && addr[1:0] != 2'b00) aligned = 1'b0;
`endif
        if (!legal || idxv >= DEPTH || !aligned) begin
            e.err = 1'b1;
            e.lat = 1;
            e.acc = 0;
            return e;
        end
        word = ref_mem[idxv[6:0]];
        bsh = int'(addr[1:0]) * 8;
        hsh = int'(addr[1]) * 16;
        m8 = 32'hFF;
        m16 = 32'hFFFF;
        if (!we) begin
            b = (word >> bsh) & m8;
            h = (word >> hsh) & m16;
            case (f3)
                3'd0:    e.rdata = (b >= 128) ? (b + 32'hFFFFFF00) : b;
                3'd1:    e.rdata = (h >= 32768) ? (h + 32'hFFFF0000) : h;
                3'd4:    e.rdata = b;
                3'd5:    e.rdata = h;
                default: e.rdata = word;
            endcase
            e.lat = 2;
            e.acc = 1;
        end else if (f3 == 3'd2) begin
            ref_mem[idxv[6:0]] = wdata;
            e.lat = 2;
            e.acc = 1;
        end else begin
            if (f3 == 3'd0) begin
                ref_mem[idxv[6:0]] = (word & ~(m8 << bsh)) | ((wdata & m8) << bsh);
            end else begin
                ref_mem[idxv[6:0]] = (word & ~(m16 << hsh)) | ((wdata & m16) << hsh);
            end
            e.lat = 3;
            e.acc = 2;
        end
        return e;
    endfunction

    // Monitor: tracks accepts, counts memory-access cycles per request and
    // compares every response against the model, away from the rising edge.
    always @(negedge clk) begin
        if (rst_n && !monitorQuiet) begin
            checkOutput("rd_we_exclusive", {31'b0, mem_read & mem_we}, 32'h0);
            if (prevResp) begin
                checkOutput("resp_pulse_width", {31'b0, resp_valid}, 32'h0);
                checkOutput("resp_rdata_clear", resp_rdata, 32'h0);
                checkOutput("resp_err_clear", {31'b0, resp_err}, 32'h0);
            end
            if (mem_read || mem_we) begin
                if (!curValid) begin
                    checkOutput("stray_access", {31'b0, mem_read | mem_we}, 32'h0);
                end else begin
                    cur.seenAcc = cur.seenAcc + 1;
                    checkOutput("mem_addr", mem_addr, cur.idx);
                end
            end
            if (resp_valid) begin
                respCount++;
                lastRdata = resp_rdata;
                lastErr = resp_err;
                if (!curValid) begin
                    checkOutput("stray_resp", {31'b0, resp_valid}, 32'h0);
                end else begin
                    checkOutput("resp_rdata", resp_rdata, cur.rdata);
                    checkOutput("resp_err", {31'b0, resp_err}, {31'b0, cur.err});
                    checkOutput("latency", cyc + 1 - cur.acceptCyc, cur.lat);
                    checkOutput("mem_access_cycles", cur.seenAcc, cur.acc);
                    curValid = 1'b0;
                end
            end
            if (req_valid && req_ready) begin
                if (pending.size() == 0) begin
                    checkOutput("unexpected_accept", {31'b0, req_ready}, 32'h0);
                end else begin
                    cur = pending.pop_front();
                    cur.acceptCyc = cyc + 1;
                    cur.seenAcc = 0;
                    curValid = 1'b1;
                    acceptLog.push_back(cyc + 1);
                end
            end else if (curValid && (cyc + 1 - cur.acceptCyc) > 6) begin
                checkOutput("resp_timeout", cyc + 1 - cur.acceptCyc, cur.lat);
                curValid = 1'b0;
            end
            prevResp = resp_valid;
        end else begin
            prevResp = 1'b0;
        end
    end

    // Drive one request until it is accepted; with hold the valid stays high
    // so the next call queues up behind it.
    task automatic applyStimulus(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] wdata, input bit hold);
        expect_t e;
        int      n;
        e = modelReq(we, f3, addr, wdata);
        pending.push_back(e);
        req_we = we;
        req_funct3 = f3;
        req_addr = addr;
        req_wdata = wdata;
        req_valid = 1'b1;
        @(negedge clk);
        n = 1;
        while (!req_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            checkOutput("accept_timeout", {31'b0, req_ready}, 32'h1);
            void'(pending.pop_back());
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        if (!hold) req_valid = 1'b0;
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        while ((curValid || pending.size() != 0) && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) checkOutput("idle_timeout", n, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int n0;
        int r0;
        clk = 1'b0;
        rst_n = 1'b0;
        req_valid = 1'b0;
        req_we = 1'b0;
        req_funct3 = 3'b000;
        req_addr = '0;
        req_wdata = '0;
        for (int i = 0; i < DEPTH; i++) preloadWord(i, 32'h1000_0000 + 32'(i * 3));
        preloadWord(9, 32'd33);
        preloadWord(5, 32'h1122_3344);

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_req_ready", {31'b0, req_ready}, 32'h1);
        checkOutput("rst_resp_valid", {31'b0, resp_valid}, 32'h0);
        checkOutput("rst_resp_rdata", resp_rdata, 32'h0);
        checkOutput("rst_resp_err", {31'b0, resp_err}, 32'h0);
        checkOutput("rst_mem_we", {31'b0, mem_we}, 32'h0);
        checkOutput("rst_mem_read", {31'b0, mem_read}, 32'h0);
        checkOutput("rst_mem_addr", mem_addr, 32'h0);
        checkOutput("rst_mem_wd", mem_wd, 32'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // LW word 9.
        applyStimulus(1'b0, 3'b010, 32'd36, 32'h0, 1'b0);
        waitIdle();
        checkOutput("lw36_rdata", lastRdata, 32'd33);
        checkOutput("lw36_err", {31'b0, lastErr}, 32'h0);

        // SB lane 1 of word 5.
        applyStimulus(1'b1, 3'b000, 32'd21, 32'h0000_00AB, 1'b0);
        waitIdle();
        checkOutput("sb21_word5", mem[5], 32'h1122_AB44);

        // Sign/zero extension on word 5.
        preloadWord(5, 32'h80FF_0001);
        applyStimulus(1'b0, 3'b000, 32'd22, 32'h0, 1'b0);
        waitIdle();
        checkOutput("lb22", lastRdata, 32'hFFFF_FFFF);
        applyStimulus(1'b0, 3'b100, 32'd22, 32'h0, 1'b0);
        waitIdle();
        checkOutput("lbu22", lastRdata, 32'h0000_00FF);
        applyStimulus(1'b0, 3'b001, 32'd22, 32'h0, 1'b0);
        waitIdle();
        checkOutput("lh22", lastRdata, 32'hFFFF_80FF);
        applyStimulus(1'b0, 3'b101, 32'd20, 32'h0, 1'b0);
        waitIdle();
        checkOutput("lhu20", lastRdata, 32'h0000_0001);

        // Out-of-range index and illegal width codes.
        applyStimulus(1'b0, 3'b010, 32'd260, 32'h0, 1'b0);
        waitIdle();
        checkOutput("lw260_err", {31'b0, lastErr}, 32'h1);
        checkOutput("lw260_rdata", lastRdata, 32'h0);
        applyStimulus(1'b0, 3'b011, 32'd0, 32'h0, 1'b0);
        waitIdle();
        applyStimulus(1'b1, 3'b100, 32'd4, 32'h1234_5678, 1'b0);
        waitIdle();
        checkOutput("illegal_store_err", {31'b0, lastErr}, 32'h1);

        // Misaligned accesses.
        applyStimulus(1'b0, 3'b001, 32'd21, 32'h0, 1'b0);
        waitIdle();
        applyStimulus(1'b1, 3'b010, 32'd6, 32'hDEAD_BEEF, 1'b0);
        waitIdle();
`ifdef LSU_ALIGN_CHECK_EN
        checkOutput("sw6_err", {31'b0, lastErr}, 32'h1);
        checkOutput("sw6_word1", mem[1], 32'h1000_0003);
`else
        checkOutput("sw6_err", {31'b0, lastErr}, 32'h0);
        checkOutput("sw6_word1", mem[1], 32'hDEAD_BEEF);
`endif

        // SH upper half of word 5.
        applyStimulus(1'b1, 3'b001, 32'd22, 32'h0000_1234, 1'b0);
        waitIdle();
        checkOutput("sh22_word5", mem[5], 32'h1234_0001);

        // Reset while the SH sequence sits in WRITE.
        monitorQuiet = 1'b1;
        req_we = 1'b1;
        req_funct3 = 3'b001;
        req_addr = 32'd20;
        req_wdata = 32'h0000_BEEF;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        checkOutput("rmw_read_phase", {31'b0, mem_read}, 32'h1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("rst_gates_we", {31'b0, mem_we}, 32'h0);
        checkOutput("rst_gates_read", {31'b0, mem_read}, 32'h0);
        @(posedge clk);
        #1;
        checkOutput("midrst_req_ready", {31'b0, req_ready}, 32'h1);
        checkOutput("midrst_resp_valid", {31'b0, resp_valid}, 32'h0);
        checkOutput("midrst_resp_rdata", resp_rdata, 32'h0);
        checkOutput("midrst_resp_err", {31'b0, resp_err}, 32'h0);
        checkOutput("midrst_mem_addr", mem_addr, 32'h0);
        checkOutput("midrst_mem_wd", mem_wd, 32'h0);
        rst_n = 1'b1;
        #1;
        checkOutput("midrst_mem_we", {31'b0, mem_we}, 32'h0);
        checkOutput("midrst_mem_read", {31'b0, mem_read}, 32'h0);
        checkOutput("midrst_word5", mem[5], 32'h1234_0001);
        @(posedge clk);
        #1;
        monitorQuiet = 1'b0;
        applyStimulus(1'b0, 3'b010, 32'd20, 32'h0, 1'b0);
        waitIdle();
        checkOutput("lw20_after_rst", lastRdata, 32'h1234_0001);

        // Back-to-back LW/LW/SW with req_valid held high.
        n0 = acceptLog.size();
        r0 = respCount;
        applyStimulus(1'b0, 3'b010, 32'd36, 32'h0, 1'b1);
        applyStimulus(1'b0, 3'b010, 32'd20, 32'h0, 1'b1);
        applyStimulus(1'b1, 3'b010, 32'd40, 32'h0000_0055, 1'b0);
        waitIdle();
        if (acceptLog.size() >= n0 + 3) begin
            checkOutput("accept_gap_1", acceptLog[n0 + 1] - acceptLog[n0], 3);
            checkOutput("accept_gap_2", acceptLog[n0 + 2] - acceptLog[n0 + 1], 3);
        end else begin
            checkOutput("accept_count", acceptLog.size() - n0, 3);
        end
        checkOutput("held_resp_count", respCount - r0, 3);
        checkOutput("sw40_word10", mem[10], 32'h0000_0055);

        // SB top lane.
        applyStimulus(1'b1, 3'b000, 32'd23, 32'h0000_007F, 1'b0);
        waitIdle();
        checkOutput("sb23_word5", mem[5], 32'h7F34_0001);

        checkOutput("pending_empty", pending.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Core-side initiator for the data memory. It accepts one load/store request at a time from the execute stage. It converts the byte address into a word index and drives the memory's `addr`/`wd`/`we`/`MemRead` pins. Sub-word stores are performed as a read-modify-write sequence. Load data is sign- or zero-extended and returned with a one-cycle response pulse.

## Interface
- `DATA_WIDTH`, default 32 (`` `DATA_WIDTH``): data and byte-address width.
- `DEPTH`, default 65: number of memory words. Legal word indices are 0..DEPTH-1.
- `clk` input, 1 bit: clock; all state changes on the rising edge.
- `rst_n` input, 1 bit: reset, synchronous, active-low.
- `req_valid` input, 1 bit: request present.
- `req_ready` output, 1 bit: block can accept a request.
- `req_we` input, 1 bit: 1 = store, 0 = load.
- `req_funct3` input, 3 bits: RV32I width code. Loads: LB=000, LH=001, LW=010, LBU=100, LHU=101. Stores: SB=000, SH=001, SW=010.
- `req_addr` input, DATA_WIDTH bits: byte address.
- `req_wdata` input, DATA_WIDTH bits: store data; low bytes used for SB/SH.
- `resp_valid` output, 1 bit: one-cycle completion pulse.
- `resp_rdata` output, DATA_WIDTH bits: load result; 0 for stores and errors.
- `resp_err` output, 1 bit: access rejected; qualified by `resp_valid`.
- `mem_addr` output, DATA_WIDTH bits: word index to memory.
- `mem_wd` output, DATA_WIDTH bits: write data to memory.
- `mem_we` output, 1 bit: memory write enable; memory writes on the next rising edge.
- `mem_read` output, 1 bit: memory read enable.
- `mem_rd` input, DATA_WIDTH bits: memory read data. Combinational from `mem_addr` while `mem_read`=1; reads 0 otherwise.

## Operation
- States: IDLE, ACCESS, WRITE, DONE. Reset state is IDLE.
- `req_ready` = (state==IDLE).
- Handshake: a request is accepted on an edge where `req_valid` && `req_ready`. On that edge, latch we/funct3/addr/wdata, set word index = addr>>2 and lane = addr[1:0].
- Request check at accept time; a request is rejected if any of the following hold:
  - funct3 is not legal for the direction.
  - word index ≥ DEPTH.
  - The access is misaligned (see Configuration).
- A rejected request goes directly IDLE→DONE with `resp_err`=1 and no memory access.
- IDLE→ACCESS for a valid request.
- ACCESS, load:
  - Drive `mem_read`=1 and `mem_addr`=index.
  - Select the byte or halfword at the lane, then sign-extend (LB/LH), zero-extend (LBU/LHU) or pass through (LW).
  - Register the result into `resp_rdata`; go to DONE.
- ACCESS, SW: drive `mem_we`=1 and `mem_wd`=wdata; go to DONE.
- ACCESS, SB/SH:
  - Drive `mem_read`=1.
  - Register a merged word: `mem_rd` with the addressed byte replaced by wdata[7:0], or the addressed halfword replaced by wdata[15:0].
  - Go to WRITE.
- WRITE: drive `mem_we`=1 and `mem_wd`=merged word at the same `mem_addr`; go to DONE.
- DONE: `resp_valid`=1 for exactly one cycle; go to IDLE.
- `mem_read` and `mem_we` are never both 1. Both are 0 outside ACCESS/WRITE.
- `mem_addr` holds the latched index between requests.

## Timing
- Reset: on an edge with `rst_n`=0, state←IDLE and every registered output ←0. `mem_we` and `mem_read` are combinationally gated by `rst_n`, so no memory write occurs on an edge where `rst_n` is sampled low, even mid-sequence (ACCESS or WRITE).
- Latency is counted from the accept edge to the edge where `resp_valid` is sampled high:
  - Loads and SW: 2 cycles.
  - SB/SH: 3 cycles.
  - Rejected requests: 1 cycle.
- Throughput: one request per 3 cycles (loads/SW), 4 cycles (SB/SH), 2 cycles (rejects). `req_ready` rises the cycle after DONE.
- `req_valid` held while `req_ready`=0 is ignored; it is accepted once the block returns to IDLE.
- `resp_rdata`/`resp_err` are valid only while `resp_valid`=1 and clear to 0 on the following edge.

## Configuration
- `LSU_ALIGN_CHECK_EN` defined:
  - LH/LHU/SH with addr[0]=1 are rejected with `resp_err`=1.
  - LW/SW with addr[1:0]≠0 are rejected with `resp_err`=1.
- `LSU_ALIGN_CHECK_EN` undefined:
  - No alignment check is performed.
  - Halfword lane is forced to addr[1]; word accesses ignore addr[1:0].
  - `resp_err` is raised only for illegal funct3 or out-of-range index.

## Test plan
- Word 9 preloaded with 33; LW at addr 36 → `mem_addr`=9, `mem_read`=1 in ACCESS; `resp_valid` 2 cycles after accept; `resp_rdata`=33, `resp_err`=0.
- Word 5 = 0x11223344; SB addr 21, wdata 0xAB → read then write in consecutive cycles; word 5 = 0x1122AB44; `resp_valid` at 3 cycles.
- Word 5 = 0x80FF0001:
  - LB addr 22 → 0xFFFFFFFF.
  - LBU addr 22 → 0x000000FF.
  - LH addr 22 → 0xFFFF80FF.
  - LHU addr 20 → 0x00000001.
- LW addr 260 (index 65) → `resp_err`=1, `resp_rdata`=0, no `mem_read`/`mem_we` pulse, `resp_valid` 1 cycle after accept. With `LSU_ALIGN_CHECK_EN`, SW addr 6 → `resp_err`=1 and memory unchanged.
- SH addr 20, wdata 0xBEEF; `rst_n` low on the edge where the FSM is in WRITE → word 5 unchanged; state IDLE; all outputs 0; a subsequent LW returns the original word.
- `req_valid` held high continuously for LW/LW/SW → accepts spaced 3 cycles apart; exactly one `resp_valid` pulse per request.
